// File: rtl/wb_obi_bridge_pkg.sv
// Shared types and sizing helpers for the Wishbone-classic-slave to OBI-master bridge.
package wb_obi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        ACK  = 3'd3,
        ERR  = 3'd4
    } wb_obi_state_e;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 256;
    localparam int unsigned TO_CNT_W = $clog2(TIMEOUT_CYC_DEFAULT + 1);

    // Counter must hold the value TIMEOUT_CYC itself; keep at least one bit when disabled.
    function automatic int unsigned to_cnt_width(input int unsigned timeout_cyc);
        return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/wb_obi_bridge.sv
// Wishbone classic slave to OBI master bridge: one outstanding transfer, response
// timeout reported as wb_err_o, cycle abort tolerated without retracting the OBI request.
module wb_obi_bridge
    import wb_obi_bridge_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [ADDR_W-1:0] ADDR_OFFSET = '0,
    parameter int unsigned       TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                  obi_clk_i,
    input  logic                  rst_ni,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [DATA_W/8-1:0]   wb_sel_i,
    input  logic [ADDR_W-1:0]     wb_adr_i,
    input  logic [DATA_W-1:0]     wb_dat_i,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [ADDR_W-1:0]     obi_addr_o,
    output logic                  obi_we_o,
    output logic [DATA_W/8-1:0]   obi_be_o,
    output logic [DATA_W-1:0]     obi_wdata_o,
    input  logic                  obi_rvalid_i,
    input  logic [DATA_W-1:0]     obi_rdata_i,
    output logic                  timeout_o
);

    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned CNT_W   = to_cnt_width(TIMEOUT_CYC);
    localparam int unsigned TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    wb_obi_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              abort_q, abort_d;
    logic              timeout_q, timeout_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              expired;
    logic              abort_now;

    // Once the counter reaches the limit it saturates, so any later wait cycle also expires.
    assign expired   = (TIMEOUT_CYC != 0) && (cnt_q >= CNT_W'(TO_LAST));
    assign cnt_inc   = (cnt_q == CNT_W'(TIMEOUT_CYC)) ? cnt_q : cnt_q + CNT_W'(1);
    assign abort_now = abort_q | ~wb_cyc_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        timeout_d = timeout_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_d  = wb_adr_i + ADDR_OFFSET;
                    we_d    = wb_we_i;
                    be_d    = wb_sel_i;
                    wdata_d = wb_dat_i;
                    abort_d = 1'b0;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                abort_d = abort_now;
                cnt_d   = cnt_inc;
                if (obi_gnt_i) begin
                    state_d = RESP;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = ERR;
                end
            end
            RESP: begin
                abort_d = abort_now;
                cnt_d   = cnt_inc;
                if (obi_rvalid_i) begin
                    if (!we_q) begin
                        rdata_d = obi_rdata_i;
                    end
                    state_d = abort_now ? IDLE : ACK;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = ERR;
                end
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge obi_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // Every output comes straight from a register or a decode of the state register.
    assign obi_req_o   = (state_q == REQ);
    assign wb_ack_o    = (state_q == ACK);
    assign wb_err_o    = (state_q == ERR) & ~abort_q;
    assign obi_addr_o  = addr_q;
    assign obi_we_o    = we_q;
    assign obi_be_o    = be_q;
    assign obi_wdata_o = wdata_q;
    assign wb_dat_o    = rdata_q;
    assign timeout_o   = timeout_q;

endmodule

// File: doc/wb_obi_bridge.md
Name: wb_obi_bridge

Overview:
- Wishbone classic slave to OBI master bridge; the reverse direction of obi_wb_bridge.
- Lets Wishbone-side masters (Smartwave peripherals, debug/config agents) reach SoC memory and registers over OBI.
- One outstanding transfer at a time, single clock domain (obi_clk_i).
- A response timeout reports stalled OBI slaves to Wishbone as wb_err_o.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width on both sides; must be a multiple of 8.
- ADDR_OFFSET, 32'h0, added to wb_adr_i to form obi_addr_o; sum taken modulo 2^ADDR_W.
- TIMEOUT_CYC, 256, max cycles from entering REQ until rvalid; 0 disables the timeout.

Ports:
- obi_clk_i  in  1  clock for all logic
- rst_ni  in  1  reset, asynchronous, active-low
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  1=write, 0=read
- wb_sel_i  in  DATA_W/8  byte selects
- wb_adr_i  in  ADDR_W  Wishbone address
- wb_dat_i  in  DATA_W  write data
- wb_dat_o  out  DATA_W  read data
- wb_ack_o  out  1  transfer complete
- wb_err_o  out  1  transfer failed (timeout)
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  ADDR_W  OBI address
- obi_we_o  out  1  OBI write enable
- obi_be_o  out  DATA_W/8  OBI byte enables
- obi_wdata_o  out  DATA_W  OBI write data
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  DATA_W  OBI read data
- timeout_o  out  1  sticky flag; set on any timeout, cleared only by reset

Behaviour:
- Reset: state IDLE; all outputs 0, including wb_dat_o, obi_addr_o and timeout_o; timeout counter 0.
- All outputs are registered or decoded directly from the state register; no combinational path from input to output.
- FSM states: IDLE, REQ, RESP, ACK, ERR.
- IDLE:
  - On wb_cyc_i & wb_stb_i: latch obi_addr_o = wb_adr_i + ADDR_OFFSET, obi_we_o = wb_we_i, obi_be_o = wb_sel_i, obi_wdata_o = wb_dat_i; clear abort flag; go to REQ.
  - obi_rvalid_i arriving in IDLE is ignored.
- REQ:
  - obi_req_o = 1; address and control held stable.
  - On obi_gnt_i go to RESP; obi_req_o falls the following cycle.
  - obi_rvalid_i in REQ is ignored (OBI returns rvalid at the earliest one cycle after gnt).
- RESP:
  - Wait for obi_rvalid_i.
  - On rvalid: capture wb_dat_o = obi_rdata_i on reads (on writes wb_dat_o holds its previous value).
  - Then go to ACK, or to IDLE if the abort flag is set.
- ACK: wb_ack_o = 1 for exactly one cycle, then IDLE.
  - Minimum latency, request to ack: 3 cycles (IDLE→REQ, gnt in the first REQ cycle, rvalid in the first RESP cycle).
- Abort: wb_cyc_i low in REQ or RESP sets the abort flag.
  - The OBI transfer still completes; the bridge never retracts req before gnt.
  - No ack or err is issued.
- Timeout (TIMEOUT_CYC > 0):
  - Counter clears on IDLE→REQ and increments every REQ/RESP cycle.
  - When it reaches TIMEOUT_CYC: go to ERR, drop obi_req_o, set timeout_o.
- ERR: wb_err_o = 1 for one cycle (suppressed if aborted), then IDLE. A late rvalid afterwards is ignored.
- gnt and timeout expiring in the same cycle: gnt wins.
- rvalid and timeout expiring in the same cycle: rvalid wins.
- wb_ack_o and wb_err_o are never asserted together.
- Reset mid-transfer: immediate return to IDLE with all outputs 0; no pending ack.

Decomposition:
- wb_obi_bridge_pkg holds the state enum (wb_obi_state_e) and a localparam for the counter width, $clog2(TIMEOUT_CYC+1).
- No sub-module; the counter is inline.

Test Plan:
- Read: wb_adr_i=0x10, ADDR_OFFSET=0x2000_0000; gnt immediate; rvalid one cycle later with rdata=0xDEADBEEF → obi_addr_o=0x2000_0010, wb_dat_o=0xDEADBEEF, wb_ack_o 1 cycle, 3-cycle latency.
- Write: wb_dat_i=0xA5A5_5A5A, wb_sel_i=4'b0011; gnt after 4 stall cycles → obi_req_o stays high 5 cycles with stable addr/be/wdata, obi_we_o=1, single ack.
- Timeout: TIMEOUT_CYC=8, gnt never given → obi_req_o drops after 8 cycles, wb_err_o one cycle, timeout_o stays 1; the next request then completes normally.
- Abort: wb_cyc_i drops during RESP; rvalid 2 cycles later → no ack or err, FSM back in IDLE; a following read returns correct data.
- Boundaries:
  - ADDR_OFFSET=0xFFFF_FFF0 with wb_adr_i=0x20 → obi_addr_o=0x10 (wrap).
  - gnt and timeout expiring in the same cycle → RESP entered, no err.
- Reset asserted in RESP → all outputs 0 within the same cycle; a later stray rvalid is ignored.
